// File: rtl/regfile_read_queue.sv
// Decoupled read front-end for a register file with a combinational read port.
// Requests are queued, issued one per cycle and captured into a response FIFO.
module regfile_read_queue #(
  parameter int unsigned width = 32,
  parameter int unsigned n     = 5,
  parameter int unsigned depth = 4,
  parameter int unsigned logd  = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [n-1:0]     REQ_IDX,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  output logic [width-1:0] RESP_DATA,
  output logic             RESP_VALID,
  input  logic             RESP_READY,
  output logic [n-1:0]     RF_IDX,
  output logic             RF_IDX_VALID,
  input  logic [width-1:0] RF_DATA,
  input  logic             RF_DATA_VALID,
  input  logic             RF_DONE,
  output logic             ERR
);

  localparam int unsigned CW = logd + 1;
  localparam logic [CW-1:0] FULL = CW'(depth);

  logic [n-1:0]     req_mem  [depth];
  logic [width-1:0] resp_mem [depth];
  logic [logd-1:0]  req_rd, req_wr, resp_rd, resp_wr;
  logic [CW-1:0]    req_count, resp_count;
  logic             enq, deq, issue, resp_space;

  // Handshakes and issue decision; a full request FIFO never passes through.
  always_comb begin
    REQ_READY    = RST_N && (req_count != FULL);
    RESP_VALID   = RST_N && (resp_count != '0);
    enq          = REQ_VALID && REQ_READY;
    deq          = RESP_VALID && RESP_READY;
    resp_space   = (resp_count != FULL) || deq;
    issue        = RST_N && RF_DONE && (req_count != '0) && resp_space;
    RF_IDX_VALID = issue;
    RF_IDX       = req_mem[req_rd];
    RESP_DATA    = resp_mem[resp_rd];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      req_rd     <= '0;
      req_wr     <= '0;
      resp_rd    <= '0;
      resp_wr    <= '0;
      req_count  <= '0;
      resp_count <= '0;
      ERR        <= 1'b0;
    end else begin
      if (enq)   req_wr  <= req_wr + logd'(1);
      if (issue) req_rd  <= req_rd + logd'(1);
      if (issue) resp_wr <= resp_wr + logd'(1);
      if (deq)   resp_rd <= resp_rd + logd'(1);

      if (enq && !issue)      req_count <= req_count + CW'(1);
      else if (!enq && issue) req_count <= req_count - CW'(1);

      if (issue && !deq)      resp_count <= resp_count + CW'(1);
      else if (!issue && deq) resp_count <= resp_count - CW'(1);

      if (issue && !RF_DATA_VALID) ERR <= 1'b1;
    end
  end

  // Storage needs no reset; the pointers and counts define validity.
  always_ff @(posedge CLK) begin
    if (enq)   req_mem[req_wr]   <= REQ_IDX;
    if (issue) resp_mem[resp_wr] <= RF_DATA;
  end

endmodule
